// File: rtl/bg_fetch_pkg.sv
// Shared types and constants for the background tile fetcher.
package bg_fetch_pkg;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned TX_W   = 5;
    localparam int unsigned FINE_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAP0,
        ST_MAP1,
        ST_LO0,
        ST_LO1,
        ST_HI0,
        ST_HI1,
        ST_PUSH
    } bg_fetch_state_t;

    localparam logic [ADDR_W-1:0] MAP1_OFS         = 13'h0400;
    localparam logic [ADDR_W-1:0] TILE_SIGNED_BASE = 13'h1000;

    localparam logic PLANE_LO = 1'b0;
    localparam logic PLANE_HI = 1'b1;

    // One tile row as handed to the background shifter.
    typedef struct packed {
        logic [7:0] hi;
        logic [7:0] lo;
    } tile_row_t;

    // Row within the 256-line background, wrapping at 8 bits.
    function automatic logic [7:0] fine_y(input logic [7:0] ly, input logic [7:0] scy);
        return 8'(ly + scy);
    endfunction

endpackage

// File: rtl/bg_tile_fetcher_if.sv
// VRAM fetch bus and background-shifter load port of the tile fetcher.
interface bg_tile_fetcher_if;

    logic [12:0] vram_addr;
    logic        vram_rd;
    logic [7:0]  vram_data;
    logic        pipe_empty;
    logic [7:0]  plane_lo;
    logic [7:0]  plane_hi;
    logic        load;
    logic [2:0]  discard;

    modport master (
        output vram_addr, vram_rd, plane_lo, plane_hi, load, discard,
        input  vram_data, pipe_empty
    );

    modport slave (
        input  vram_addr, vram_rd, plane_lo, plane_hi, load, discard,
        output vram_data, pipe_empty
    );

endinterface

// File: rtl/bg_fetch_addr.sv
// Combinational VRAM address formation: tile-map or tile-data address.
// With BG_FETCH_WINDOW_EN the fine Y can come from the window line counter.
module bg_fetch_addr
    import bg_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] MAP_BASE = 13'h1800
) (
    input  logic              is_map,
    input  logic              map_hi,
    input  logic [TX_W-1:0]   tx,
    input  logic [7:0]        idx,
    input  logic [7:0]        ly,
    input  logic [7:0]        scy,
`ifdef BG_FETCH_WINDOW_EN
    input  logic              use_win,
    input  logic [7:0]        win_line,
`endif
    input  logic              tile_sel,
    input  logic              plane,
    output logic [ADDR_W-1:0] addr_c
);

    logic [7:0]        fy;
    logic [ADDR_W-1:0] map_addr;
    logic [ADDR_W-1:0] tile_base;
    logic [ADDR_W-1:0] data_addr;

    always_comb begin
        fy = fine_y(ly, scy);
`ifdef BG_FETCH_WINDOW_EN
        if (use_win) fy = win_line;
`endif
        map_addr  = MAP_BASE | (map_hi ? MAP1_OFS : '0)
                  | {3'b000, fy[7:3], 5'b00000} | {8'h00, tx};
        // Signed tile addressing: indices 0..127 live at 0x1000, 128..255 at 0x0800.
        tile_base = (!tile_sel && !idx[7]) ? TILE_SIGNED_BASE : '0;
        data_addr = tile_base | {1'b0, idx, fy[FINE_W-1:0], plane};
        addr_c    = is_map ? map_addr : data_addr;
    end

endmodule

// File: rtl/bg_tile_fetcher.sv
// DMG PPU background tile fetcher: map read, two plane reads, shifter load.
// Optional window support is compiled in with BG_FETCH_WINDOW_EN.
module bg_tile_fetcher
    import bg_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] MAP_BASE    = 13'h1800,
    parameter int unsigned       STEP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       line_start,
    input  logic       line_end,
    input  logic [7:0] scx,
    input  logic [7:0] scy,
    input  logic [7:0] ly,
    input  logic       map_sel,
    input  logic       tile_sel,
`ifdef BG_FETCH_WINDOW_EN
    input  logic       win_en,
    input  logic       win_map_sel,
    input  logic       win_trigger,
    input  logic       frame_start,
`endif
    bg_tile_fetcher_if.master bus
);

    generate
        if (STEP_CYCLES != 2) begin : g_step_chk
            $error("bg_tile_fetcher: only STEP_CYCLES == 2 is implemented");
        end
    endgenerate

    bg_fetch_state_t   state, state_n;
    logic [TX_W-1:0]   tx, tx_n;
    logic [FINE_W-1:0] discard_q, discard_n;
    logic [7:0]        idx, idx_n;
    tile_row_t         row, row_n;
    logic [ADDR_W-1:0] addr_q, addr_n, addr_c;
    logic              rd_q, rd_n;
    logic              load_q, load_n;
    logic              is_map, plane, map_hi;

`ifdef BG_FETCH_WINDOW_EN
    logic       win_active, win_active_n;
    logic [7:0] win_line;
    assign map_hi = win_active_n ? win_map_sel : map_sel;
`else
    assign map_hi = map_sel;
`endif

    // State register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= ST_IDLE;
        else         state <= state_n;
    end

    // Next state and next tile/data values; line_start beats line_end
    always_comb begin
        state_n   = state;
        tx_n      = tx;
        discard_n = discard_q;
        idx_n     = idx;
        row_n     = row;
`ifdef BG_FETCH_WINDOW_EN
        win_active_n = win_active;
`endif
        if (line_start) begin
            state_n   = ST_MAP0;
            tx_n      = scx[7:3];
            discard_n = scx[2:0];
`ifdef BG_FETCH_WINDOW_EN
            win_active_n = 1'b0;
`endif
        end
`ifdef BG_FETCH_WINDOW_EN
        else if (win_en && win_trigger) begin
            state_n      = ST_MAP0;
            tx_n         = '0;
            discard_n    = '0;
            win_active_n = 1'b1;
        end
`endif
        else if (line_end) begin
            state_n = ST_IDLE;
`ifdef BG_FETCH_WINDOW_EN
            win_active_n = 1'b0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: state_n = ST_IDLE;
                ST_MAP0: state_n = ST_MAP1;
                ST_MAP1: begin
                    state_n = ST_LO0;
                    idx_n   = bus.vram_data;
                end
                ST_LO0:  state_n = ST_LO1;
                ST_LO1: begin
                    state_n  = ST_HI0;
                    row_n.lo = bus.vram_data;
                end
                ST_HI0:  state_n = ST_HI1;
                ST_HI1: begin
                    state_n  = ST_PUSH;
                    row_n.hi = bus.vram_data;
                end
                ST_PUSH: begin
                    // The load pulse is already on the wire this cycle.
                    if (load_q) begin
                        state_n = ST_MAP0;
                        tx_n    = TX_W'(tx + 1'b1);
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign is_map = (state_n == ST_MAP0);
    assign plane  = (state_n == ST_HI0) ? PLANE_HI : PLANE_LO;

    bg_fetch_addr #(.MAP_BASE(MAP_BASE)) u_addr (
        .is_map   (is_map),
        .map_hi   (map_hi),
        .tx       (tx_n),
        .idx      (idx_n),
        .ly       (ly),
        .scy      (scy),
`ifdef BG_FETCH_WINDOW_EN
        .use_win  (win_active_n),
        .win_line (win_line),
`endif
        .tile_sel (tile_sel),
        .plane    (plane),
        .addr_c   (addr_c)
    );

    // Registered bus outputs decoded from the state being entered
    always_comb begin
        addr_n = addr_q;
        rd_n   = 1'b0;
        load_n = 1'b0;
        unique case (state_n)
            ST_IDLE: addr_n = '0;
            ST_MAP0, ST_LO0, ST_HI0: begin
                rd_n   = 1'b1;
                addr_n = addr_c;
            end
            ST_MAP1, ST_LO1, ST_HI1: rd_n = 1'b1;
            ST_PUSH: load_n = bus.pipe_empty;
            default: addr_n = '0;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tx        <= '0;
            discard_q <= '0;
            idx       <= '0;
            row       <= '0;
            addr_q    <= '0;
            rd_q      <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            tx        <= tx_n;
            discard_q <= discard_n;
            idx       <= idx_n;
            row       <= row_n;
            addr_q    <= addr_n;
            rd_q      <= rd_n;
            load_q    <= load_n;
        end
    end

`ifdef BG_FETCH_WINDOW_EN
    // Window line counter advances only on lines that showed the window
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            win_active <= 1'b0;
            win_line   <= '0;
        end else begin
            win_active <= win_active_n;
            if (frame_start)                  win_line <= '0;
            else if (line_end && win_active)  win_line <= 8'(win_line + 1'b1);
        end
    end
`endif

    assign bus.vram_addr = addr_q;
    assign bus.vram_rd   = rd_q;
    assign bus.plane_lo  = row.lo;
    assign bus.plane_hi  = row.hi;
    assign bus.load      = load_q;
    assign bus.discard   = discard_q;

endmodule

// File: tb/tb_bg_tile_fetcher.sv
// Self-checking bench for bg_tile_fetcher against an arithmetic fetch model.
module tb_bg_tile_fetcher;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       line_start = 1'b0;
    logic       line_end = 1'b0;
    logic [7:0] scx = '0;
    logic [7:0] scy = '0;
    logic [7:0] ly = '0;
    logic       map_sel = 1'b0;
    logic       tile_sel = 1'b1;
    logic       pipe_empty = 1'b1;

    logic [7:0] mem [8192];
    logic [7:0] exp_lo = '0;
    logic [7:0] exp_hi = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bg_tile_fetcher_if bus();
    assign bus.vram_data  = mem[bus.vram_addr];
    assign bus.pipe_empty = pipe_empty;

    bg_tile_fetcher #(.MAP_BASE(13'h1800), .STEP_CYCLES(2)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .line_start (line_start),
        .line_end   (line_end),
        .scx        (scx),
        .scy        (scy),
        .ly         (ly),
        .map_sel    (map_sel),
        .tile_sel   (tile_sel),
        .bus        (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    endtask

    // Pulse line_start; returns in the first MAP0 cycle.
    task automatic start_line(input logic [7:0] s);
        scx = s;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    // Walks one full fetch from its MAP0 cycle, optionally stalling in PUSH.
    task automatic fetch_tile(input logic [4:0] tx, input int stall);
        int fy, ma, la, idx;
        logic [12:0] exp_a;
        fy  = (int'(ly) + int'(scy)) % 256;
        ma  = 'h1800 + (map_sel ? 'h400 : 0) + (fy / 8) * 32 + int'(tx);
        idx = int'(mem[13'(ma)]);
        la  = ((tile_sel || idx >= 128) ? 0 : 'h1000) + idx * 16 + (fy % 8) * 2;
        for (int c = 1; c <= 6; c++) begin
            exp_a = (c <= 2) ? 13'(ma) : (c <= 4) ? 13'(la) : 13'(la + 1);
            n_checks++;
            if (bus.vram_rd !== 1'b1 || bus.vram_addr !== exp_a) begin
                n_fail++;
                $display("FAIL fetch tx=%0d cycle=%0d: rd=%b addr=%h, required rd=1 addr=%h",
                         tx, c, bus.vram_rd, bus.vram_addr, exp_a);
            end
            if (c == 6) pipe_empty = (stall == 0);
            tick();
        end
        exp_lo = mem[13'(la)];
        exp_hi = mem[13'(la + 1)];
        for (int s = 0; s < stall; s++) begin
            n_checks++;
            if (bus.load !== 1'b0 || bus.vram_rd !== 1'b0 ||
                bus.plane_lo !== exp_lo || bus.plane_hi !== exp_hi) begin
                n_fail++;
                $display("FAIL stall tx=%0d s=%0d: load=%b rd=%b lo=%h hi=%h, required load=0 rd=0 lo=%h hi=%h",
                         tx, s, bus.load, bus.vram_rd, bus.plane_lo, bus.plane_hi, exp_lo, exp_hi);
            end
            tick();
        end
        if (stall > 0) begin
            pipe_empty = 1'b1;
            n_checks++;
            if (bus.load !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_release tx=%0d: load=%b, required 0", tx, bus.load);
            end
            tick();
        end
        n_checks++;
        if (bus.load !== 1'b1 || bus.vram_rd !== 1'b0 ||
            bus.plane_lo !== exp_lo || bus.plane_hi !== exp_hi) begin
            n_fail++;
            $display("FAIL push tx=%0d: load=%b rd=%b lo=%h hi=%h, required load=1 rd=0 lo=%h hi=%h",
                     tx, bus.load, bus.vram_rd, bus.plane_lo, bus.plane_hi, exp_lo, exp_hi);
        end
        tick();
    endtask

    task automatic test_reset();
        fill_mem();
        repeat (3) tick();
        n_checks++;
        if (bus.vram_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd: %b, required 0", bus.vram_rd); end
        n_checks++;
        if (bus.vram_addr !== 13'h0) begin n_fail++; $display("FAIL reset_addr: %h, required 0", bus.vram_addr); end
        n_checks++;
        if (bus.plane_lo !== 8'h0 || bus.plane_hi !== 8'h0) begin
            n_fail++; $display("FAIL reset_planes: %h/%h, required 00/00", bus.plane_lo, bus.plane_hi);
        end
        n_checks++;
        if (bus.load !== 1'b0) begin n_fail++; $display("FAIL reset_load: %b, required 0", bus.load); end
        n_checks++;
        if (bus.discard !== 3'd0) begin n_fail++; $display("FAIL reset_discard: %0d, required 0", bus.discard); end
        nreset = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (bus.vram_rd !== 1'b0 || bus.load !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: rd=%b load=%b, required 0/0", bus.vram_rd, bus.load);
        end
    endtask

    task automatic test_basic();
        scy = 8'h00; ly = 8'h00; map_sel = 1'b0; tile_sel = 1'b1;
        mem[13'h1800] = 8'h05;
        start_line(8'h00);
        n_checks++;
        if (bus.vram_addr !== 13'h1800) begin
            n_fail++; $display("FAIL first_map_addr: %h, required 1800", bus.vram_addr);
        end
        fetch_tile(5'd0, 0);
        fetch_tile(5'd1, 0);
    endtask

    task automatic test_signed_tiles();
        tile_sel = 1'b0; scy = 8'h00; ly = 8'h00;
        mem[13'h1800] = 8'h80;
        start_line(8'h00);
        fetch_tile(5'd0, 0);
        ly = 8'h03;
        mem[13'h1800] = 8'h7F;
        start_line(8'h00);
        fetch_tile(5'd0, 0);
        tile_sel = 1'b1;
    endtask

    task automatic test_fy_wrap();
        scy = 8'hF8; ly = 8'h10;
        start_line(8'h00);
        n_checks++;
        if (bus.vram_addr !== 13'h1820) begin
            n_fail++; $display("FAIL fy_wrap_map_addr: %h, required 1820", bus.vram_addr);
        end
        fetch_tile(5'd0, 0);
    endtask

    task automatic test_scx_wrap();
        scy = 8'h00; ly = 8'h00;
        start_line(8'hFD);
        n_checks++;
        if (bus.discard !== 3'd5) begin n_fail++; $display("FAIL discard: %0d, required 5", bus.discard); end
        n_checks++;
        if (bus.vram_addr !== 13'h181F) begin
            n_fail++; $display("FAIL scx_first_addr: %h, required 181F", bus.vram_addr);
        end
        fetch_tile(5'd31, 0);
        n_checks++;
        if (bus.vram_addr !== 13'h1800) begin
            n_fail++; $display("FAIL tx_wrap_addr: %h, required 1800", bus.vram_addr);
        end
        fetch_tile(5'd0, 0);
    endtask

    task automatic test_stall();
        scy = 8'h21; ly = 8'h44; map_sel = 1'b1;
        start_line(8'h40);
        fetch_tile(5'd8, 10);
        fetch_tile(5'd9, 0);
        map_sel = 1'b0;
    endtask

    task automatic test_line_end();
        scy = 8'h00; ly = 8'h09;
        start_line(8'h10);
        fetch_tile(5'd2, 0);
        tick();
        line_end = 1'b1;
        tick();
        line_end = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.vram_rd !== 1'b0 || bus.load !== 1'b0 || bus.vram_addr !== 13'h0 ||
                bus.plane_lo !== exp_lo || bus.plane_hi !== exp_hi) begin
                n_fail++;
                $display("FAIL line_end i=%0d: rd=%b load=%b addr=%h lo=%h hi=%h, required 0/0/0000 lo=%h hi=%h",
                         i, bus.vram_rd, bus.load, bus.vram_addr, bus.plane_lo, bus.plane_hi, exp_lo, exp_hi);
            end
            tick();
        end
        // line_start and line_end together: the new line wins.
        line_end = 1'b1;
        start_line(8'h38);
        line_end = 1'b0;
        fetch_tile(5'd7, 0);
    endtask

    task automatic test_async_reset();
        scy = 8'h00; ly = 8'h00;
        start_line(8'h00);
        repeat (3) tick();
        #2;
        nreset = 1'b0;
        #1;
        n_checks++;
        if (bus.vram_rd !== 1'b0) begin
            n_fail++; $display("FAIL async_rd_drop: %b, required 0", bus.vram_rd);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 5) begin #2; nreset = 1'b1; end
            n_checks++;
            if (bus.vram_rd !== 1'b0 || bus.load !== 1'b0) begin
                n_fail++; $display("FAIL after_reset i=%0d: rd=%b load=%b, required 0/0", i, bus.vram_rd, bus.load);
            end
        end
        n_checks++;
        if (bus.plane_lo !== 8'h0 || bus.plane_hi !== 8'h0) begin
            n_fail++; $display("FAIL reset_planes_cleared: %h/%h, required 00/00", bus.plane_lo, bus.plane_hi);
        end
        start_line(8'h00);
        fetch_tile(5'd0, 0);
    endtask

    task automatic test_random();
        logic [7:0] s;
        for (int l = 0; l < 6; l++) begin
            fill_mem();
            s        = 8'($urandom);
            scy      = 8'($urandom);
            ly       = 8'($urandom_range(0, 143));
            map_sel  = 1'($urandom);
            tile_sel = 1'($urandom);
            start_line(s);
            n_checks++;
            if (bus.discard !== s[2:0]) begin
                n_fail++; $display("FAIL rand_discard line=%0d: %0d, required %0d", l, bus.discard, s[2:0]);
            end
            for (int t = 0; t < 4; t++)
                fetch_tile(5'(int'(s[7:3]) + t), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed_tiles();
        test_fy_wrap();
        test_scx_wrap();
        test_stall();
        test_line_end();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
